tile_sequence_renderer: RTL and testbench
=========================================

Name: tile_sequence_renderer

Overview:
- Parametrised playback engine for the memory-tile game: takes a packed tile-index sequence and flashes each tile on the 160x120 VGA plot interface.
- Each tile is painted lit, held, repainted unlit, followed by a gap.
- Generalises the fixed 4-tile / fixed-length flash path to N tiles, configurable geometry, sequence length and timing.
- Sits between the game control FSM (start/len/seq) and the vga_adapter plot inputs.

Parameters:
- NUM_TILES, 4, number of tiles; index width IDX_W = clog2(NUM_TILES), minimum 1.
- MAX_LEN, 9, maximum sequence elements; LEN_W = clog2(MAX_LEN+1).
- TILE_SIZE, 16, square tile edge in pixels.
- X0, 8, x origin of tile 0.
- Y0, 40, y origin of all tiles.
- TILE_PITCH, 36, x distance between successive tile origins.
- FLASH_CYCLES, 25000000, clocks a tile stays lit after painting.
- GAP_CYCLES, 12500000, clocks after unlit repaint before the next element.

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin playback; sampled only in IDLE
- abort  in  1  synchronous; return to IDLE from any state
- seq_len  in  LEN_W  number of elements to play
- seq  in  MAX_LEN*IDX_W  packed indices, element 0 at LSBs
- x  out  8  plot x
- y  out  7  plot y
- colour  out  3  plot colour
- plot  out  1  write enable to vga_adapter
- busy  out  1  high from the cycle after start until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- pos  out  LEN_W  index of element currently playing
- bad_index  out  1  sticky: an element >= NUM_TILES was skipped; cleared on start

Behaviour:
- Reset (async, resetn=0): state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0, pos=0, bad_index=0; latched seq/len cleared.
- States: IDLE, FETCH, DRAW_ON, HOLD, DRAW_OFF, GAP, FINISH.
- IDLE: on start=1, latch seq and min(seq_len, MAX_LEN), clear pos and bad_index, then go to FETCH. Latched values are immune to later input changes.
- FETCH (1 cycle):
  - pos == len: go to FINISH.
  - Index >= NUM_TILES: set bad_index, pos+1, stay in FETCH.
  - Otherwise: load the tile origin (X0 + idx*TILE_PITCH, Y0), clear the pixel counters, go to DRAW_ON.
- DRAW_ON:
  - One pixel per cycle, plot=1, raster order (x inner, y outer).
  - TILE_SIZE*TILE_SIZE cycles, then go to HOLD.
  - Lit colour = (idx mod 7)+1; never 0.
- HOLD: plot=0 for FLASH_CYCLES, then go to DRAW_OFF.
- DRAW_OFF: same pixel walk as DRAW_ON with colour=3'b000, then go to GAP.
- GAP: GAP_CYCLES idle, then pos+1 and go to FETCH.
- FINISH: done=1 for exactly one cycle, busy=0 the next cycle, then go to IDLE.
- Latency: start in cycle 0 gives busy=1 and FETCH in cycle 1, and the first plot in cycle 2.
- seq_len=0: FETCH goes straight to FINISH, so done pulses in cycle 2 with no plots.
- seq_len > MAX_LEN: clamped to MAX_LEN.
- abort: takes priority over all transitions. Next cycle the block is in IDLE with plot=0 and busy=0; no done pulse. A tile may be left lit on screen.
- start while busy: ignored. Simultaneous start and abort in IDLE: abort wins, and the block stays in IDLE.
- Coordinates: computed at full width, then truncated to 8/7 bits. Geometry that overruns 160x120 is a configuration error and is not checked.
- Delay counters are sized to the larger of FLASH_CYCLES and GAP_CYCLES. A value of 0 means the state lasts exactly 1 cycle.

Optional Feature:
- Macro: TILE_CLEAR_ON_START_EN.
- Defined: after start, a CLEAR state paints every tile 0..NUM_TILES-1 unlit (NUM_TILES*TILE_SIZE^2 plot cycles) before the first FETCH. The first plot is still in cycle 2; element plotting is shifted accordingly.
- Undefined: no CLEAR state; the block goes directly to FETCH.

Test Plan:
Bench parameters: NUM_TILES=4, TILE_SIZE=4, FLASH_CYCLES=10, GAP_CYCLES=5, X0=8, Y0=40, TILE_PITCH=20.
- Reset mid-DRAW_ON (resetn low) -> all outputs 0 immediately; after release the block is IDLE and ignores stale seq.
- seq_len=1, seq[1:0]=2, start pulse -> busy at cycle 1; 16 plots at cycle 2..17 covering x 48..51, y 40..43, colour 3; 10 idle cycles; 16 plots colour 0; 5 gap cycles; done pulse once; busy then 0.
- seq_len=3, seq={1,3,0} with element 0 = 0 -> tiles played in order 0,3,1 with colours 1,4,2; pos steps 0,1,2; a single done pulse.
- seq_len=0 -> done at cycle 2, zero plot cycles.
- NUM_TILES=3, element 1 = 3 within seq_len=2 -> element 1 skipped with no plots; bad_index=1; done pulses; next start clears bad_index.
- abort during HOLD -> IDLE next cycle, no done pulse. Start during busy has no effect. With TILE_CLEAR_ON_START_EN defined -> 64 colour-0 plots precede the first lit plot.

Source files
------------

// File: rtl/tile_sequence_renderer.sv
// Memory-tile playback engine: flashes a packed sequence of tile indices onto the 160x120 plot port.
// Optional TILE_CLEAR_ON_START_EN: paint every tile unlit before the first element.
module tile_sequence_renderer #(
  parameter int NUM_TILES    = 4,
  parameter int MAX_LEN      = 9,
  parameter int TILE_SIZE    = 16,
  parameter int X0           = 8,
  parameter int Y0           = 40,
  parameter int TILE_PITCH   = 36,
  parameter int FLASH_CYCLES = 25000000,
  parameter int GAP_CYCLES   = 12500000,
  localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  localparam int LEN_W = (MAX_LEN > 0) ? $clog2(MAX_LEN + 1) : 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [LEN_W-1:0]         seq_len,
  input  logic [MAX_LEN*IDX_W-1:0] seq,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [2:0]               colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_W-1:0]         pos,
  output logic                     bad_index
);

  localparam int SEQ_W   = MAX_LEN * IDX_W;
  localparam int PX_W    = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam int DLY_MAX = (FLASH_CYCLES > GAP_CYCLES) ? FLASH_CYCLES : GAP_CYCLES;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  localparam logic [PX_W-1:0]  PX_LAST    = PX_W'(TILE_SIZE - 1);
  localparam logic [DLY_W-1:0] FLASH_LAST = DLY_W'((FLASH_CYCLES > 0) ? FLASH_CYCLES - 1 : 0);
  localparam logic [DLY_W-1:0] GAP_LAST   = DLY_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
  localparam logic [6:0]       Y_ORG      = 7'(Y0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DRAW_ON  = 3'd2,
    S_HOLD     = 3'd3,
    S_DRAW_OFF = 3'd4,
    S_GAP      = 3'd5,
    S_FINISH   = 3'd6,
    S_CLEAR    = 3'd7
  } state_e;

  // Origin arithmetic is done at full width; truncation mod 256 keeps per-pixel sums exact.
  function automatic logic [7:0] tile_x(input int idx);
    return 8'(X0 + idx * TILE_PITCH);
  endfunction

  function automatic logic [2:0] lit_colour(input logic [IDX_W-1:0] idx);
    return 3'((int'(idx) % 7) + 1);
  endfunction

  state_e             state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   pos_q, pos_d;
  logic               bad_q, bad_d;
  logic [PX_W-1:0]    px_q, px_d;
  logic [PX_W-1:0]    py_q, py_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [7:0]         org_x_q, org_x_d;
  logic [7:0]         x_q, x_d;
  logic [6:0]         y_q, y_d;
  logic [2:0]         colour_q, colour_d;
  logic               plot_q, plot_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef TILE_CLEAR_ON_START_EN
  localparam logic [IDX_W-1:0] CT_LAST = IDX_W'(NUM_TILES - 1);
  logic [IDX_W-1:0]   ct_q, ct_d;
`endif

  logic [IDX_W-1:0]   cur_idx_s;
  logic               idx_bad_s;
  logic               px_last_s, py_last_s, tile_end_s;
  logic [PX_W-1:0]    px_nx_s, py_nx_s;

  assign cur_idx_s  = IDX_W'(seq_q >> (pos_q * IDX_W));
  assign idx_bad_s  = (int'(cur_idx_s) >= NUM_TILES);
  assign px_last_s  = (px_q == PX_LAST);
  assign py_last_s  = (py_q == PX_LAST);
  assign tile_end_s = px_last_s && py_last_s;
  assign px_nx_s    = px_last_s ? {PX_W{1'b0}} : (px_q + PX_W'(1));
  assign py_nx_s    = !px_last_s ? py_q : (py_last_s ? {PX_W{1'b0}} : (py_q + PX_W'(1)));

  // Next-state and next-output logic; plot registers are loaded one cycle ahead of display.
  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    len_d    = len_q;
    pos_d    = pos_q;
    bad_d    = bad_q;
    px_d     = px_q;
    py_d     = py_q;
    dly_d    = dly_q;
    org_x_d  = org_x_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
`ifdef TILE_CLEAR_ON_START_EN
    ct_d     = ct_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            seq_d = seq;
            len_d = (seq_len > MAX_LEN_L) ? MAX_LEN_L : seq_len;
            pos_d = {LEN_W{1'b0}};
            bad_d = 1'b0;
`ifdef TILE_CLEAR_ON_START_EN
            ct_d    = {IDX_W{1'b0}};
            px_d    = {PX_W{1'b0}};
            py_d    = {PX_W{1'b0}};
            state_d = S_CLEAR;
`else
            state_d = S_FETCH;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
`ifdef TILE_CLEAR_ON_START_EN
        // Counters here name the pixel about to be emitted, not the one on display.
        S_CLEAR: begin
          plot_d   = 1'b1;
          colour_d = 3'b000;
          x_d      = tile_x(int'(ct_q)) + 8'(px_q);
          y_d      = Y_ORG + 7'(py_q);
          px_d     = px_nx_s;
          py_d     = py_nx_s;
          if (tile_end_s) begin
            ct_d    = ct_q + IDX_W'(1);
            state_d = (ct_q == CT_LAST) ? S_FETCH : S_CLEAR;
          end else begin
            state_d = S_CLEAR;
          end
        end
`endif
        S_FETCH: begin
          if (pos_q == len_q) begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else if (idx_bad_s) begin
            bad_d = 1'b1;
            pos_d = pos_q + LEN_ONE;
          end else begin
            org_x_d  = tile_x(int'(cur_idx_s));
            px_d     = {PX_W{1'b0}};
            py_d     = {PX_W{1'b0}};
            plot_d   = 1'b1;
            x_d      = tile_x(int'(cur_idx_s));
            y_d      = Y_ORG;
            colour_d = lit_colour(cur_idx_s);
            state_d  = S_DRAW_ON;
          end
        end
        S_DRAW_ON, S_DRAW_OFF: begin
          if (tile_end_s) begin
            dly_d   = {DLY_W{1'b0}};
            state_d = (state_q == S_DRAW_ON) ? S_HOLD : S_GAP;
          end else begin
            px_d   = px_nx_s;
            py_d   = py_nx_s;
            plot_d = 1'b1;
            x_d    = org_x_q + 8'(px_nx_s);
            y_d    = Y_ORG + 7'(py_nx_s);
          end
        end
        S_HOLD: begin
          if (dly_q == FLASH_LAST) begin
            px_d     = {PX_W{1'b0}};
            py_d     = {PX_W{1'b0}};
            plot_d   = 1'b1;
            x_d      = org_x_q;
            y_d      = Y_ORG;
            colour_d = 3'b000;
            state_d  = S_DRAW_OFF;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
        S_GAP: begin
          if (dly_q == GAP_LAST) begin
            pos_d   = pos_q + LEN_ONE;
            state_d = S_FETCH;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      seq_q    <= {SEQ_W{1'b0}};
      len_q    <= {LEN_W{1'b0}};
      pos_q    <= {LEN_W{1'b0}};
      bad_q    <= 1'b0;
      px_q     <= {PX_W{1'b0}};
      py_q     <= {PX_W{1'b0}};
      dly_q    <= {DLY_W{1'b0}};
      org_x_q  <= 8'd0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TILE_CLEAR_ON_START_EN
      ct_q     <= {IDX_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      len_q    <= len_d;
      pos_q    <= pos_d;
      bad_q    <= bad_d;
      px_q     <= px_d;
      py_q     <= py_d;
      dly_q    <= dly_d;
      org_x_q  <= org_x_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TILE_CLEAR_ON_START_EN
      ct_q     <= ct_d;
`endif
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pos       = pos_q;
  assign bad_index = bad_q;

endmodule

// File: tb/tb_tile_sequence_renderer.sv
// Scoreboard bench for tile_sequence_renderer: expected pixels queued at start, compared against observed plots.
module tb_tile_sequence_renderer;

  localparam int NT = 4, TS = 4, FL = 10, GP = 5, XO = 8, YO = 40, PI = 20, ML = 9;
  localparam int ELEM = 2 * TS * TS + FL + GP + 1;
`ifdef TILE_CLEAR_ON_START_EN
  localparam int CLR = NT * TS * TS;
  localparam int CLR3 = 3 * TS * TS;
`else
  localparam int CLR = 0;
  localparam int CLR3 = 0;
`endif

  typedef struct packed {
    logic [31:0] e;
    logic [17:0] pix;
  } obs_t;

  logic        clock = 1'b0;
  logic        resetn, start, abort;
  logic [3:0]  seq_len;
  logic [17:0] seq;
  logic [7:0]  x, x3;
  logic [6:0]  y, y3;
  logic [2:0]  colour, colour3;
  logic        plot, busy, done, bad_index;
  logic        plot3, busy3, done3, bad3;
  logic [3:0]  pos, pos3;

  int vectors = 0, miscompares = 0;
  int edge_cnt = 0, base = 0;
  int done_cnt = 0, done_edge = 0, done3_cnt = 0, plot3_cnt = 0;
  logic [17:0] exp_q[$];
  obs_t        obs_q[$];

  tile_sequence_renderer #(.NUM_TILES(NT), .MAX_LEN(ML), .TILE_SIZE(TS), .X0(XO), .Y0(YO),
    .TILE_PITCH(PI), .FLASH_CYCLES(FL), .GAP_CYCLES(GP)) dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort), .seq_len(seq_len), .seq(seq),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done), .pos(pos),
    .bad_index(bad_index));

  tile_sequence_renderer #(.NUM_TILES(3), .MAX_LEN(ML), .TILE_SIZE(TS), .X0(XO), .Y0(YO),
    .TILE_PITCH(PI), .FLASH_CYCLES(FL), .GAP_CYCLES(GP)) dut3 (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort), .seq_len(seq_len), .seq(seq),
    .x(x3), .y(y3), .colour(colour3), .plot(plot3), .busy(busy3), .done(done3), .pos(pos3),
    .bad_index(bad3));

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Observed plots and done pulses, time-stamped with the cycle number
  always @(negedge clock) begin
    if (plot) obs_q.push_back({32'(edge_cnt), x, y, colour});
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_edge <= edge_cnt;
    end
    if (done3) done3_cnt <= done3_cnt + 1;
    if (plot3) plot3_cnt <= plot3_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push_tile(input int idx, input int col);
    for (int yy = 0; yy < TS; yy++)
      for (int xx = 0; xx < TS; xx++)
        exp_q.push_back({8'(XO + idx * PI + xx), 7'(YO + yy), 3'(col)});
  endtask

  task automatic push_clear();
`ifdef TILE_CLEAR_ON_START_EN
    for (int t = 0; t < NT; t++) push_tile(t, 0);
`endif
  endtask

  task automatic launch(input int len, input logic [17:0] s);
    seq_len = 4'(len);
    seq     = s;
    start   = 1'b1;
    base    = edge_cnt;
    tick();
    start   = 1'b0;
  endtask

  task automatic score(input int o0, input int total);
    logic [17:0] e;
    check_eq("plot_count", obs_q.size() - o0, total);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (o0 + i < obs_q.size()) check_eq("pixel", obs_q[o0 + i].pix, e);
    end
  endtask

  task automatic check_all_zero();
    check_eq("rst_x", x, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_colour", colour, 0);
    check_eq("rst_plot", plot, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pos", pos, 0);
    check_eq("rst_bad", bad_index, 0);
  endtask

  task automatic run_seq(input int len, input logic [17:0] s, input bit poke);
    int n, o0, d0, rel, total, idx;
    n = (len > ML) ? ML : len;
    push_clear();
    for (int k = 0; k < n; k++) begin
      idx = int'(s[2*k +: 2]);
      push_tile(idx, idx % 7 + 1);
      push_tile(idx, 0);
    end
    total = exp_q.size();
    o0 = obs_q.size();
    d0 = done_cnt;
    launch(len, s);
    check_eq("busy_cycle1", busy, 1);
    check_eq("bad_cleared", bad_index, 0);
    check_eq("bad3_cleared", bad3, 0);
    rel = edge_cnt - base;
    while (done_cnt == d0 && rel < 4000) begin
      if (poke && rel == 10) begin
        start   = 1'b1;
        seq_len = 4'd9;
        seq     = 18'h3FFFF;
      end else begin
        start = 1'b0;
      end
      for (int k = 0; k < n; k++)
        if (rel == CLR + 2 + ELEM * k) check_eq("pos", pos, k);
      tick();
      rel = edge_cnt - base;
    end
    start = 1'b0;
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("done_cycle", done_edge - base, CLR + 2 + ELEM * n);
    tick();
    check_eq("busy_after_done", busy, 0);
    check_eq("done_width", done, 0);
    if (total > 0 && obs_q.size() > o0) check_eq("first_plot_cycle", obs_q[o0].e - base, 2);
    score(o0, total);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int o0, d0, d3, p3, rel, total;
    resetn = 1'b0; start = 1'b0; abort = 1'b0; seq_len = 4'd0; seq = 18'd0;
    repeat (3) tick();
    check_all_zero();
    resetn = 1'b1;
    tick();

    // single tile 2, with a start poke while busy
    run_seq(1, 18'h00002, 1'b1);
    // elements 0,3,1
    run_seq(3, 18'h0001C, 1'b0);
    // empty sequence
    run_seq(0, 18'h00003, 1'b0);

    // element 1 = 3 is out of range only for the 3-tile instance
    d3 = done3_cnt;
    p3 = plot3_cnt;
    run_seq(2, 18'h0000D, 1'b0);
    check_eq("bad3_set", bad3, 1);
    check_eq("done3_count", done3_cnt - d3, 1);
    check_eq("plot3_count", plot3_cnt - p3, CLR3 + 2 * TS * TS);
    check_eq("bad_main", bad_index, 0);
    run_seq(1, 18'h00001, 1'b0);

    // length above MAX_LEN clamps to nine elements
    run_seq(12, 18'h2D3B6, 1'b0);

    // abort during HOLD
    push_clear();
    push_tile(1, 2);
    total = exp_q.size();
    o0 = obs_q.size();
    d0 = done_cnt;
    launch(1, 18'h00001);
    rel = edge_cnt - base;
    while (rel < CLR + 22) begin
      tick();
      rel = edge_cnt - base;
    end
    check_eq("hold_plot", plot, 0);
    check_eq("hold_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_plot", plot, 0);
    repeat (60) tick();
    check_eq("abort_no_done", done_cnt - d0, 0);
    score(o0, total);

    // start and abort together in IDLE
    o0 = obs_q.size();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("start_abort_busy", busy, 0);
      tick();
    end
    score(o0, 0);

    // asynchronous reset in the middle of DRAW_ON
    launch(1, 18'h00000);
    rel = edge_cnt - base;
    while (rel < CLR + 5) begin
      tick();
      rel = edge_cnt - base;
    end
    check_eq("mid_draw_plot", plot, 1);
    resetn = 1'b0;
    #1;
    check_all_zero();
    tick();
    resetn = 1'b1;
    o0 = obs_q.size();
    d0 = done_cnt;
    repeat (40) tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_done", done_cnt - d0, 0);
    score(o0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
